// File: rtl/arbiter_pkg.sv
// Shared encodings and a width helper for the QoS round-robin arbiter.
package arbiter_pkg;
    localparam logic ARB_PACKET = 1'b0;
    localparam logic ARB_CYCLE  = 1'b1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Ceiling log2, never below 1 so a two-requester build still has a grant bit.
    function automatic int log2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/qos_arbiter_rr_select.sv
// Combinational round-robin picker: first set bit strictly above ptr, wrapping.
module rr_select #(
    parameter int WIDTH   = 8,
    parameter int GRANT_W = 3
) (
    input  logic [WIDTH-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] idx,
    output logic               found
);
    logic [WIDTH-1:0] rot;
    int               base;
    int               pos;

    always_comb begin
        base = int'(ptr) + 1;
        if (base >= WIDTH) base = 0;
        // rot[k] holds requester (base + k) mod WIDTH
        rot   = (req >> base) | (req << (WIDTH - base));
        found = 1'b0;
        pos   = 0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                pos   = base + k;
            end
        end
        if (pos >= WIDTH) pos = pos - WIDTH;
        idx = GRANT_W'(pos);
    end
endmodule

// File: rtl/qos_arbiter.sv
// Weighted round-robin arbiter with ready handshake and zero-bubble hand-over.
// Optional QOS_ARBITER_URGENT_EN adds an urgent vector that wins arbitration first.
module qos_arbiter
    import arbiter_pkg::*;
#(
    parameter int    WIDTH    = 8,
    parameter string ARB_TYPE = "PACKET",
    parameter int    WEIGHT_W = 4,
    localparam int   GRANT_W  = log2(WIDTH)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          requests,
    input  logic [WIDTH*WEIGHT_W-1:0] weights,
`ifdef QOS_ARBITER_URGENT_EN
    input  logic [WIDTH-1:0]          urgent,
`endif
    input  logic                      ready,
    output logic [GRANT_W-1:0]        grant,
    output logic [WIDTH-1:0]          grant_onehot,
    output logic                      valid,
    output logic                      last
);
    localparam logic ARB_MODE = (ARB_TYPE == "CYCLE") ? ARB_CYCLE : ARB_PACKET;

    logic [0:0]                       state;
    logic [GRANT_W-1:0]               ptr;
    logic [WEIGHT_W-1:0]              credit;
    logic [WIDTH-1:0][WEIGHT_W-1:0]   wt;
    logic [GRANT_W-1:0]               sel_ptr;
    logic [GRANT_W-1:0]               pick;
    logic                             pick_found;
    logic                             acc;
    logic                             beat_rel;
    logic                             release_now;
    logic                             load;

    assign wt = weights;

    // On release the pointer moves to the holder in the same edge, so arbitrate from it.
    assign sel_ptr = (state == HOLD) ? grant : ptr;

`ifdef QOS_ARBITER_URGENT_EN
    logic [WIDTH-1:0]   urg_req;
    logic [GRANT_W-1:0] urg_idx, all_idx;
    logic               urg_found;

    assign urg_req = requests & urgent;

    rr_select #(.WIDTH(WIDTH), .GRANT_W(GRANT_W)) u_sel_urg (
        .req(urg_req), .ptr(sel_ptr), .idx(urg_idx), .found(urg_found)
    );
    rr_select #(.WIDTH(WIDTH), .GRANT_W(GRANT_W)) u_sel_all (
        .req(requests), .ptr(sel_ptr), .idx(all_idx), .found(pick_found)
    );
    assign pick = urg_found ? urg_idx : all_idx;
`else
    rr_select #(.WIDTH(WIDTH), .GRANT_W(GRANT_W)) u_sel_all (
        .req(requests), .ptr(sel_ptr), .idx(pick), .found(pick_found)
    );
`endif

    assign acc         = valid & ready;
    assign beat_rel    = acc & ((credit == WEIGHT_W'(1)) | (ARB_MODE == ARB_CYCLE));
    assign release_now = (state == HOLD) & (~requests[grant] | beat_rel);
    assign load        = (state == IDLE) | release_now;
    assign last        = beat_rel;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= GRANT_W'(WIDTH - 1);
            credit       <= '0;
            grant        <= '0;
            grant_onehot <= '0;
            valid        <= 1'b0;
        end else if (load) begin
            if (state == HOLD) ptr <= grant;
            if (pick_found) begin
                state        <= HOLD;
                valid        <= 1'b1;
                grant        <= pick;
                grant_onehot <= {{(WIDTH-1){1'b0}}, 1'b1} << pick;
                credit       <= wt[pick];
            end else begin
                state        <= IDLE;
                valid        <= 1'b0;
                grant        <= '0;
                grant_onehot <= '0;
                credit       <= '0;
            end
        end else if (acc && credit != '0) begin
            // zero credit means unlimited and is never decremented
            credit <= credit - 1'b1;
        end
    end
endmodule

// File: tb/tb_qos_arbiter.sv
// Self-checking bench for qos_arbiter: directed table, hand sequences, randomized model compare.
module tb_qos_arbiter;
    localparam int W  = 8;
    localparam int WW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [W-1:0]    requests = '0;
    logic [W*WW-1:0] weights = '0;
    logic            ready = 1'b1;
`ifdef QOS_ARBITER_URGENT_EN
    logic [W-1:0]    urgent = '0;
`endif
    logic [2:0]      g_p, g_c;
    logic [W-1:0]    oh_p, oh_c;
    logic            v_p, v_c, l_p, l_c;

    int total  = 0;
    int passed = 0;

    always #5 clock = ~clock;

    qos_arbiter #(.WIDTH(W), .ARB_TYPE("PACKET"), .WEIGHT_W(WW)) u_pkt (
        .clock(clock), .reset(reset), .requests(requests), .weights(weights),
`ifdef QOS_ARBITER_URGENT_EN
        .urgent(urgent),
`endif
        .ready(ready), .grant(g_p), .grant_onehot(oh_p), .valid(v_p), .last(l_p)
    );

    qos_arbiter #(.WIDTH(W), .ARB_TYPE("CYCLE"), .WEIGHT_W(WW)) u_cyc (
        .clock(clock), .reset(reset), .requests(requests), .weights(weights),
`ifdef QOS_ARBITER_URGENT_EN
        .urgent(urgent),
`endif
        .ready(ready), .grant(g_c), .grant_onehot(oh_c), .valid(v_c), .last(l_c)
    );

    // Reference model: who holds the grant, the round-robin pointer, beats left (0 = unlimited).
    typedef struct { int holder; int ptr; int left; } mst_t;
    mst_t mp, mc;

    typedef struct { logic [7:0] req; logic rdy; logic v; logic [2:0] g; logic l; } vec_t;
    vec_t tbl [19];

    function automatic logic [W-1:0] urg_now();
`ifdef QOS_ARBITER_URGENT_EN
        return urgent;
`else
        return '0;
`endif
    endfunction

    function automatic int pick(logic [W-1:0] req, logic [W-1:0] urg, int p);
        logic [W-1:0] cand;
        cand = ((req & urg) != 0) ? (req & urg) : req;
        for (int k = 1; k <= W; k++)
            if (cand[(p + k) % W]) return (p + k) % W;
        return -1;
    endfunction

    function automatic int wt(logic [W*WW-1:0] w, int i);
        return int'(w[i*WW +: WW]);
    endfunction

    function automatic mst_t step(mst_t s, logic [W-1:0] req, logic [W*WW-1:0] w,
                                  logic rdy, logic [W-1:0] urg, bit cyc);
        mst_t n;
        n = s;
        if (s.holder < 0) begin
            if (req != 0) begin
                n.holder = pick(req, urg, s.ptr);
                n.left   = wt(w, n.holder);
            end
        end else if (!req[s.holder] || (rdy && (s.left == 1 || cyc))) begin
            n.ptr = s.holder;
            if (req != 0) begin
                n.holder = pick(req, urg, n.ptr);
                n.left   = wt(w, n.holder);
            end else begin
                n.holder = -1;
                n.left   = 0;
            end
        end else if (rdy && s.left > 0) begin
            n.left = s.left - 1;
        end
        return n;
    endfunction

    // Packed as {valid, grant, onehot, last}
    function automatic logic [12:0] expo(mst_t s, logic rdy, bit cyc);
        logic       v;
        logic [2:0] g;
        logic [7:0] oh;
        logic       l;
        v  = (s.holder >= 0);
        g  = v ? 3'(s.holder) : 3'd0;
        oh = v ? (8'd1 << s.holder) : 8'd0;
        l  = v && rdy && (s.left == 1 || cyc);
        return {v, g, oh, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; requests = '0; ready = 1'b1;
        #1;
        mp = '{holder: -1, ptr: W - 1, left: 0};
        mc = '{holder: -1, ptr: W - 1, left: 0};
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int exp5 [4];
        exp5 = '{0, 1, 3, 0};

        // reset with requests pending, then first grant after release
        requests = 8'b01101010;
        #1;
        chk("reset_outputs", {v_p, g_p, oh_p}, 12'h000);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); #1;
        chk("first_grant", {v_p, g_p, oh_p}, {1'b1, 3'd1, 8'b00000010});

        // packet hand-over, quantum exhaustion, ready stall
        tbl[0]  = '{8'b01101010, 1'b1, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'b01101010, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[2]  = '{8'b01101000, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[3]  = '{8'b01101000, 1'b1, 1'b1, 3'd3, 1'b0};
        tbl[4]  = '{8'b01100000, 1'b1, 1'b1, 3'd3, 1'b0};
        tbl[5]  = '{8'b01100000, 1'b1, 1'b1, 3'd5, 1'b0};
        tbl[6]  = '{8'b01100000, 1'b1, 1'b1, 3'd5, 1'b0};
        tbl[7]  = '{8'b01100000, 1'b1, 1'b1, 3'd5, 1'b1};
        tbl[8]  = '{8'b01100000, 1'b1, 1'b1, 3'd6, 1'b0};
        tbl[9]  = '{8'b01100000, 1'b1, 1'b1, 3'd6, 1'b1};
        tbl[10] = '{8'b01100000, 1'b0, 1'b1, 3'd5, 1'b0};
        tbl[11] = '{8'b01100000, 1'b0, 1'b1, 3'd5, 1'b0};
        tbl[12] = '{8'b01100000, 1'b0, 1'b1, 3'd5, 1'b0};
        tbl[13] = '{8'b01100000, 1'b0, 1'b1, 3'd5, 1'b0};
        tbl[14] = '{8'b01100000, 1'b1, 1'b1, 3'd5, 1'b0};
        tbl[15] = '{8'b01100000, 1'b1, 1'b1, 3'd5, 1'b0};
        tbl[16] = '{8'b01100000, 1'b1, 1'b1, 3'd5, 1'b1};
        tbl[17] = '{8'b00000000, 1'b1, 1'b1, 3'd6, 1'b0};
        tbl[18] = '{8'b00000000, 1'b1, 1'b0, 3'd0, 1'b0};
        do_reset();
        weights = 32'h0230_0000;
        for (int i = 0; i < 19; i++) begin
            @(negedge clock);
            requests = tbl[i].req; ready = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d", i), {v_p, g_p, oh_p, l_p},
                {tbl[i].v, tbl[i].g, tbl[i].v ? (8'd1 << tbl[i].g) : 8'd0, tbl[i].l});
        end

        // CYCLE mode: one beat per grant, then idle when requests vanish
        do_reset();
        weights = '0; requests = 8'b00001011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); #1;
            chk($sformatf("cyc_seq%0d", k), {v_c, g_c, l_c}, {1'b1, 3'(exp5[k]), 1'b1});
        end
        @(negedge clock); requests = '0; #1;
        chk("cyc_drop_hold", {v_c, g_c}, {1'b1, 3'd1});
        @(negedge clock); #1;
        chk("cyc_idle", {v_c, g_c, oh_c}, 12'h000);

        // asynchronous reset in the middle of a grant
        requests = 8'b00000100;
        @(negedge clock); #1;
        chk("pre_reset_grant", {v_p, g_p}, {1'b1, 3'd2});
        #2 reset = 1'b0;
        #1;
        chk("midgrant_reset", {v_p, g_p, oh_p, v_c, g_c, oh_c}, 24'h0);
        @(negedge clock); reset = 1'b1;

`ifdef QOS_ARBITER_URGENT_EN
        do_reset();
        requests = 8'b00000010; urgent = '0;
        @(negedge clock);
        requests = 8'b10001010; urgent = 8'b10000000;
        #1;
        chk("urg_before", {v_c, g_c}, {1'b1, 3'd1});
        @(negedge clock); #1;
        chk("urg_wins", {v_c, g_c}, {1'b1, 3'd7});
        urgent = '0;
`endif

        // randomized run against the reference model, both modes share stimulus
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            if ($urandom_range(3) == 0) requests = 8'($urandom);
            if ($urandom_range(15) == 0)
                for (int f = 0; f < W; f++) weights[f*WW +: WW] = 4'($urandom_range(3));
            ready = ($urandom_range(3) != 0);
`ifdef QOS_ARBITER_URGENT_EN
            if ($urandom_range(7) == 0) urgent = 8'($urandom) & 8'($urandom);
`endif
            #1;
            chk("rnd_pkt", {v_p, g_p, oh_p, l_p}, expo(mp, ready, 1'b0));
            chk("rnd_cyc", {v_c, g_c, oh_c, l_c}, expo(mc, ready, 1'b1));
            mp = step(mp, requests, weights, ready, urg_now(), 1'b0);
            mc = step(mc, requests, weights, ready, urg_now(), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
